// File: rtl/pixel_fetch.sv
// Consumer end of the pixel-map address FIFO: pops address words, reads the frame-buffer SRAM in order, and buffers pixels for the display.
// Optional feature macro: PIXEL_FETCH_STATS_EN adds a saturating underrun event counter (oUNDERRUN_CNT).
module pixel_fetch #(
    parameter int                DATA_W      = 16,
    parameter int                ADDR_W      = 19,
    parameter int                RD_LATENCY  = 2,
    parameter int                BUF_DEPTH   = 8,
    parameter logic [DATA_W-1:0] BLANK_PIXEL = '0
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [ADDR_W:0]   iADDRESS,
    input  logic              iREADY_N,
    output logic              oREAD,
    output logic [ADDR_W-1:0] oSRAM_ADDR,
    output logic              oSRAM_RD_N,
    input  logic [DATA_W-1:0] iSRAM_DATA,
    input  logic              iPIX_REQ,
    output logic [DATA_W-1:0] oPIXEL,
    output logic              oPIX_VALID,
    output logic              oUNDERRUN,
`ifdef PIXEL_FETCH_STATS_EN
    output logic [15:0]       oUNDERRUN_CNT,
`endif
    output logic              oDBG_STATE
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {PRIME, RUN} state_t;

    state_t                state_q;
    logic [CW-1:0]         credit_q, credit_d;
    logic                  issue_q;
    logic [RD_LATENCY-1:0] slot_q, real_q;
    logic [RD_LATENCY:0]   slot_sh, real_sh;
    logic [CW-1:0]         wr_ptr_q, rd_ptr_q, level;
    logic [DATA_W-1:0]     mem_q [BUF_DEPTH];
    logic                  issue_real, wr_en, buf_empty, buf_pop;
    logic [DATA_W-1:0]     wr_data;

    // Credits cover both in-flight reads and stored pixels, so the buffer cannot overflow.
    assign oREAD      = RESET_N && !iREADY_N && (credit_q < CW'(BUF_DEPTH));
    assign issue_real = issue_q && iADDRESS[ADDR_W];
    assign oSRAM_RD_N = !issue_real;
    assign oSRAM_ADDR = issue_real ? iADDRESS[ADDR_W-1:0] : '0;

    assign slot_sh = {slot_q, issue_q};
    assign real_sh = {real_q, issue_real};
    assign wr_en   = slot_q[RD_LATENCY-1];
    assign wr_data = real_q[RD_LATENCY-1] ? iSRAM_DATA : BLANK_PIXEL;

    assign level      = wr_ptr_q - rd_ptr_q;
    assign buf_empty  = (level == '0);
    assign buf_pop    = (state_q == RUN) && iPIX_REQ && !buf_empty;
    assign credit_d   = credit_q + CW'(oREAD) - CW'(buf_pop);
    assign oDBG_STATE = (state_q == RUN);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            credit_q <= '0;
            issue_q  <= 1'b0;
            slot_q   <= '0;
            real_q   <= '0;
            wr_ptr_q <= '0;
        end else begin
            credit_q <= credit_d;
            issue_q  <= oREAD;
            slot_q   <= slot_sh[RD_LATENCY-1:0];
            real_q   <= real_sh[RD_LATENCY-1:0];
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) mem_q[wr_ptr_q[PW-1:0]] <= wr_data;
    end

    // A write landing in the same cycle as a request on an empty buffer is not bypassed.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= PRIME;
            rd_ptr_q   <= '0;
            oPIXEL     <= BLANK_PIXEL;
            oPIX_VALID <= 1'b0;
            oUNDERRUN  <= 1'b0;
        end else begin
            case (state_q)
                PRIME: begin
                    oPIX_VALID <= 1'b0;
                    oPIXEL     <= BLANK_PIXEL;
                    if (level >= CW'(BUF_DEPTH / 2)) state_q <= RUN;
                end
                RUN: begin
                    if (iPIX_REQ) begin
                        if (!buf_empty) begin
                            oPIXEL     <= mem_q[rd_ptr_q[PW-1:0]];
                            oPIX_VALID <= 1'b1;
                            rd_ptr_q   <= rd_ptr_q + 1'b1;
                        end else begin
                            oPIXEL     <= BLANK_PIXEL;
                            oPIX_VALID <= 1'b0;
                            oUNDERRUN  <= 1'b1;
                            state_q    <= PRIME;
                        end
                    end else begin
                        oPIX_VALID <= 1'b0;
                    end
                end
                default: state_q <= PRIME;
            endcase
        end
    end

`ifdef PIXEL_FETCH_STATS_EN
    logic [15:0] ucnt_q;
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ucnt_q <= '0;
        end else if ((state_q == RUN) && iPIX_REQ && buf_empty && (ucnt_q != 16'hFFFF)) begin
            ucnt_q <= ucnt_q + 16'd1;
        end
    end
    assign oUNDERRUN_CNT = ucnt_q;
`endif
endmodule
